// File: rtl/dderby_loader_pkg.sv
// Shared types and defaults for the ROM download bridge.
package dderby_loader_pkg;

  // Default sprite region bounds (byte addresses)
  localparam logic [24:0] SpBaseDefault = 25'h14000;
  localparam logic [24:0] SpEndDefault  = 25'h24000;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } loader_entry_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } loader_state_e;

  typedef enum logic [1:0] {
    PortP1,
    PortP2,
    PortDrop
  } loader_port_e;

endpackage

// File: rtl/loader_fifo.sv
// Small synchronous FIFO of download entries. A read in the same cycle as a
// write on a full FIFO frees the slot first, so the write is accepted.
module loader_fifo
  import dderby_loader_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          wr_en,
  input  loader_entry_t wr_data,
  input  logic          rd_en,
  output loader_entry_t rd_data,
  output logic          full,
  output logic          empty,
  output logic          wr_accept
);

  localparam int unsigned Aw = (Depth > 1) ? $clog2(Depth) : 1;

  loader_entry_t mem_q [Depth];
  logic [Aw-1:0] wptr_q, rptr_q;
  logic [Aw:0]   count_q;
  logic          do_rd, do_wr;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (Aw + 1)'(Depth));
  assign do_rd     = rd_en & ~empty;
  assign do_wr     = wr_en & (~full | do_rd);
  assign wr_accept = do_wr;
  assign rd_data   = mem_q[rptr_q];

  // Pointer and occupancy bookkeeping; Depth is a power of two so pointers wrap
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + 1'b1;
      if (do_rd) rptr_q <= rptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk_sys) begin
    if (do_wr) mem_q[wptr_q] <= wr_data;
  end

endmodule

// File: rtl/dderby_rom_loader.sv
// ROM download bridge: buffers data_io bytes and routes them to SDRAM write
// port 1 (CPU/sound) or port 2 (sprites), and sequences the core reset.
// Optional feature: define DDERBY_LOADER_CHECKSUM_EN to add a 16-bit byte sum.
module dderby_rom_loader
  import dderby_loader_pkg::*;
#(
  parameter logic [24:0] SP_BASE    = SpBaseDefault,
  parameter logic [24:0] SP_END     = SpEndDefault,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] RESET_HOLD = 16'hffff
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_downl,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        force_reset,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic        port1_we,
  output logic [15:0] port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [15:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic        port2_we,
  output logic [15:0] port2_d,
  output logic        rom_loaded,
  output logic        core_reset,
  output logic        overflow,
  output logic        busy
`ifdef DDERBY_LOADER_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  logic          wr_q, downl_q, push_q, we_q, done_pend_q;
  logic          push, downl_rise, downl_fall;
  loader_entry_t entry_q, head;
  logic          fifo_full, fifo_empty, fifo_wr_accept;
  loader_state_e state_q, state_d;
  loader_port_e  target_q, head_port;
  logic          pop, load_p1, load_p2, toggle_p1, toggle_p2, req_match;
  logic [24:0]   sp_off;
  logic [15:0]   reset_count_q;
  logic          unused_sp_off;

  assign push       = ioctl_downl & ioctl_wr & ~wr_q;
  assign downl_rise = ioctl_downl & ~downl_q;
  assign downl_fall = ~ioctl_downl & downl_q;

  // Input edge detection and capture of the byte on the rising strobe
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_q    <= 1'b0;
      downl_q <= 1'b0;
      push_q  <= 1'b0;
      entry_q <= '0;
    end else begin
      wr_q    <= ioctl_wr;
      downl_q <= ioctl_downl;
      push_q  <= push;
      if (push) entry_q <= '{addr: ioctl_addr, data: ioctl_dout};
    end
  end

  loader_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .wr_en     (push_q),
    .wr_data   (entry_q),
    .rd_en     (pop),
    .rd_data   (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .wr_accept (fifo_wr_accept)
  );

  assign sp_off        = head.addr - SP_BASE;
  assign unused_sp_off = ^sp_off[24:17];

  // Route the head entry by address region
  always_comb begin
    head_port = PortDrop;
    if (head.addr < SP_BASE)     head_port = PortP1;
    else if (head.addr < SP_END) head_port = PortP2;
  end

  assign req_match = (target_q == PortP2) ? (port2_ack == port2_req)
                                          : (port1_ack == port1_req);

  // Dispatcher state register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Dispatcher next state; discarded entries never leave idle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!fifo_empty && head_port != PortDrop) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (req_match) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Dispatcher strobes
  always_comb begin
    pop       = 1'b0;
    toggle_p1 = 1'b0;
    toggle_p2 = 1'b0;
    unique case (state_q)
      StIdle:  pop = ~fifo_empty;
      StIssue: begin
        toggle_p1 = (target_q == PortP1);
        toggle_p2 = (target_q == PortP2);
      end
      default: ;
    endcase
    load_p1 = pop & (head_port == PortP1);
    load_p2 = pop & (head_port == PortP2);
  end

  // Port request, address and data registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      target_q  <= PortP1;
      port1_req <= 1'b0;
      port1_a   <= '0;
      port1_ds  <= '0;
      port1_d   <= '0;
      port2_req <= 1'b0;
      port2_a   <= '0;
      port2_ds  <= '0;
      port2_d   <= '0;
    end else begin
      if (load_p1) begin
        target_q <= PortP1;
        port1_a  <= head.addr[23:1];
        port1_ds <= {head.addr[0], ~head.addr[0]};
        port1_d  <= {head.data, head.data};
      end
      if (load_p2) begin
        target_q <= PortP2;
        port2_a  <= {sp_off[14:0], sp_off[16]};
        port2_ds <= {sp_off[15], ~sp_off[15]};
        port2_d  <= {head.data, head.data};
      end
      if (toggle_p1) port1_req <= ~port1_req;
      if (toggle_p2) port2_req <= ~port2_req;
    end
  end

  // A byte in the capture stage counts as outstanding so the end of a
  // download cannot look drained before its last byte reaches the FIFO.
  assign busy     = ~fifo_empty | (state_q != StIdle) | push_q;
  assign port1_we = we_q;
  assign port2_we = we_q;

  // Download status: write enable, overflow, loaded flag
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      we_q        <= 1'b0;
      overflow    <= 1'b0;
      done_pend_q <= 1'b0;
      rom_loaded  <= 1'b0;
    end else begin
      we_q <= ioctl_downl | busy;
      if (downl_rise)                       overflow <= 1'b0;
      else if (push_q && !fifo_wr_accept)   overflow <= 1'b1;
      if (downl_rise)      done_pend_q <= 1'b0;
      else if (downl_fall) done_pend_q <= 1'b1;
      if (downl_rise)                                   rom_loaded <= 1'b0;
      else if (done_pend_q && !ioctl_downl && !busy)    rom_loaded <= 1'b1;
    end
  end

  // Core reset: held while loading or forced, plus one late second pulse
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      reset_count_q <= RESET_HOLD;
      core_reset    <= 1'b1;
    end else begin
      if (force_reset || !rom_loaded) reset_count_q <= RESET_HOLD;
      else if (reset_count_q != '0)   reset_count_q <= reset_count_q - 1'b1;
      core_reset <= force_reset | ~rom_loaded | (reset_count_q == 16'd1);
    end
  end

`ifdef DDERBY_LOADER_CHECKSUM_EN
  logic [15:0] checksum_q;

  // Running sum of accepted bytes, restarted with each download
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)            checksum_q <= '0;
    else if (downl_rise)     checksum_q <= '0;
    else if (fifo_wr_accept) checksum_q <= checksum_q + {8'h00, entry_q.data};
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_dderby_rom_loader.sv
// Directed self-checking bench for dderby_rom_loader.
module tb_dderby_rom_loader;

  localparam logic [15:0] Hold = 16'd12;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_downl = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        force_reset = 1'b0;
  logic        port1_req, port1_ack, port1_we, port2_req, port2_ack, port2_we;
  logic [22:0] port1_a;
  logic [15:0] port2_a, port1_d, port2_d;
  logic [1:0]  port1_ds, port2_ds;
  logic        rom_loaded, core_reset, overflow, busy;
`ifdef DDERBY_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int ack_delay = 3;
  int p1_cnt, p2_cnt, p1_tog, p2_tog;
  logic p1_prev, p2_prev;

  dderby_rom_loader #(
    .FIFO_DEPTH (4),
    .RESET_HOLD (Hold)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ioctl_downl (ioctl_downl),
    .ioctl_wr    (ioctl_wr),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .force_reset (force_reset),
    .port1_req   (port1_req),
    .port1_ack   (port1_ack),
    .port1_a     (port1_a),
    .port1_ds    (port1_ds),
    .port1_we    (port1_we),
    .port1_d     (port1_d),
    .port2_req   (port2_req),
    .port2_ack   (port2_ack),
    .port2_a     (port2_a),
    .port2_ds    (port2_ds),
    .port2_we    (port2_we),
    .port2_d     (port2_d),
    .rom_loaded  (rom_loaded),
    .core_reset  (core_reset),
    .overflow    (overflow),
    .busy        (busy)
`ifdef DDERBY_LOADER_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  // SDRAM-side responders: echo req onto ack after ack_delay cycles
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      port1_ack <= 1'b0;
      port2_ack <= 1'b0;
      p1_cnt    <= 0;
      p2_cnt    <= 0;
    end else begin
      if (port1_req != port1_ack) begin
        if (p1_cnt >= ack_delay - 1) begin
          port1_ack <= port1_req;
          p1_cnt    <= 0;
        end else p1_cnt <= p1_cnt + 1;
      end
      if (port2_req != port2_ack) begin
        if (p2_cnt >= ack_delay - 1) begin
          port2_ack <= port2_req;
          p2_cnt    <= 0;
        end else p2_cnt <= p2_cnt + 1;
      end
    end
  end

  // Request toggle counters
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      p1_prev <= 1'b0;
      p2_prev <= 1'b0;
    end else begin
      p1_prev <= port1_req;
      p2_prev <= port2_req;
      if (port1_req != p1_prev) p1_tog <= p1_tog + 1;
      if (port2_req != p2_prev) p2_tog <= p2_tog + 1;
    end
  end

  initial begin
    p1_tog = 0;
    p2_tog = 0;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [24:0] addr, input logic [7:0] data);
    @(negedge clk_sys);
    ioctl_addr = addr;
    ioctl_dout = data;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    ioctl_wr   = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    check_val({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int t1, t2, n, low_cnt;

    // Reset values
    repeat (3) @(negedge clk_sys);
    check_val("rst_p1_req", {31'd0, port1_req}, 32'd0);
    check_val("rst_p2_req", {31'd0, port2_req}, 32'd0);
    check_val("rst_we", {30'd0, port1_we, port2_we}, 32'd0);
    check_val("rst_p1_a", {9'd0, port1_a}, 32'd0);
    check_val("rst_rom_loaded", {31'd0, rom_loaded}, 32'd0);
    check_val("rst_core_reset", {31'd0, core_reset}, 32'd1);
    check_val("rst_overflow", {31'd0, overflow}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk_sys);
    ioctl_downl = 1'b1;
    repeat (2) @(negedge clk_sys);

    // Port 1 byte with exact request latency (wr sampled high at edge N)
    ioctl_addr = 25'h00003;
    ioctl_dout = 8'h5A;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);                       // after N
    ioctl_wr = 1'b0;
    check_val("lat_busy", {31'd0, busy}, 32'd1);
    check_val("lat_req_n", {31'd0, port1_req}, 32'd0);
    @(negedge clk_sys);                       // after N+1
    @(negedge clk_sys);                       // after N+2
    check_val("lat_req_n2", {31'd0, port1_req}, 32'd0);
    @(negedge clk_sys);                       // after N+3
    check_val("lat_req_n3", {31'd0, port1_req}, 32'd1);
    wait_idle("p1");
    check_val("p1_a", {9'd0, port1_a}, 32'h000001);
    check_val("p1_ds", {30'd0, port1_ds}, 32'h2);
    check_val("p1_d", {16'd0, port1_d}, 32'h5A5A);
    check_val("p1_tog", p1_tog, 1);
    check_val("p1_we", {31'd0, port1_we}, 32'd1);

    // Last port 1 byte below the sprite region
    send_byte(25'h13FFF, 8'hC3);
    wait_idle("p1_top");
    check_val("p1_top_a", {9'd0, port1_a}, 32'h009FFF);
    check_val("p1_top_ds", {30'd0, port1_ds}, 32'h2);
    check_val("p1_top_d", {16'd0, port1_d}, 32'hC3C3);

    // Sprite region: off 0x8001, first byte, last byte
    send_byte(25'h1C001, 8'h11);
    wait_idle("p2_mid");
    check_val("p2_mid_a", {16'd0, port2_a}, 32'h0002);
    check_val("p2_mid_ds", {30'd0, port2_ds}, 32'h2);
    check_val("p2_mid_d", {16'd0, port2_d}, 32'h1111);
    check_val("p2_mid_tog", p2_tog, 1);
    check_val("p2_mid_p1tog", p1_tog, 2);
    send_byte(25'h14000, 8'h22);
    wait_idle("p2_base");
    check_val("p2_base_a", {16'd0, port2_a}, 32'h0000);
    check_val("p2_base_ds", {30'd0, port2_ds}, 32'h1);
    send_byte(25'h23FFF, 8'h33);
    wait_idle("p2_last");
    check_val("p2_last_a", {16'd0, port2_a}, 32'hFFFE);
    check_val("p2_last_ds", {30'd0, port2_ds}, 32'h2);
    check_val("p2_last_tog", p2_tog, 3);

    // Address at the sprite end is discarded
    t1 = p1_tog;
    t2 = p2_tog;
    send_byte(25'h24000, 8'h44);
    repeat (2) @(negedge clk_sys);
    check_val("drop_busy", {31'd0, busy}, 32'd0);
    check_val("drop_p1tog", p1_tog - t1, 0);
    check_val("drop_p2tog", p2_tog - t2, 0);
    check_val("drop_p2_a", {16'd0, port2_a}, 32'hFFFE);

    // Overflow: 8 bytes, slow acks, only 5 accepted
    ack_delay = 20;
    t1 = p1_tog;
    for (int i = 0; i < 8; i++) send_byte(25'h100 + 25'(i), 8'(i));
    check_val("ovf_flag", {31'd0, overflow}, 32'd1);
    @(negedge clk_sys);
    ioctl_downl = 1'b0;
    repeat (2) @(negedge clk_sys);
    check_val("ovf_loaded_early", {31'd0, rom_loaded}, 32'd0);
    check_val("ovf_we_drain", {31'd0, port1_we}, 32'd1);
    n = 0;
    while (!rom_loaded && n < 400) begin
      @(negedge clk_sys);
      n++;
    end
    check_val("ovf_loaded", {31'd0, rom_loaded}, 32'd1);
    check_val("ovf_tog", p1_tog - t1, 5);
    check_val("ovf_ack_match", {31'd0, port1_ack}, {31'd0, port1_req});
    check_val("ovf_busy", {31'd0, busy}, 32'd0);
    check_val("ovf_a", {9'd0, port1_a}, 32'h000082);
    check_val("ovf_d", {16'd0, port1_d}, 32'h0404);

    // Second reset pulse
    n = 0;
    while (core_reset && n < 4) begin
      @(negedge clk_sys);
      n++;
    end
    check_val("crst_deassert", {31'd0, core_reset}, 32'd0);
    low_cnt = 0;
    while (!core_reset && low_cnt < 2 * Hold) begin
      low_cnt++;
      @(negedge clk_sys);
    end
    check_val("crst_gap", low_cnt, Hold - 1);
    check_val("crst_pulse", {31'd0, core_reset}, 32'd1);
    @(negedge clk_sys);
    check_val("crst_width", {31'd0, core_reset}, 32'd0);
    repeat (Hold + 4) @(negedge clk_sys);
    check_val("crst_stay_low", {31'd0, core_reset}, 32'd0);
    check_val("we_after_drain", {31'd0, port1_we}, 32'd0);
    force_reset = 1'b1;
    @(negedge clk_sys);
    check_val("force_reset", {31'd0, core_reset}, 32'd1);
    force_reset = 1'b0;

    // New download clears overflow and loaded state
    @(negedge clk_sys);
    ioctl_downl = 1'b1;
    @(negedge clk_sys);
    check_val("new_dl_ovf", {31'd0, overflow}, 32'd0);
    check_val("new_dl_loaded", {31'd0, rom_loaded}, 32'd0);
    @(negedge clk_sys);
    check_val("new_dl_crst", {31'd0, core_reset}, 32'd1);

    // Reset while a port 1 request is outstanding
    send_byte(25'h00010, 8'h77);
    repeat (4) @(negedge clk_sys);
    check_val("mid_busy", {31'd0, busy}, 32'd1);
    check_val("mid_p1_req", {31'd0, port1_req}, 32'd0);
    check_val("mid_p2_req", {31'd0, port2_req}, 32'd1);
    check_val("mid_p1_a", {9'd0, port1_a}, 32'h000008);
    reset_n = 1'b0;
    #1;
    check_val("mrst_p2_req", {31'd0, port2_req}, 32'd0);
    check_val("mrst_p1_a", {9'd0, port1_a}, 32'd0);
    check_val("mrst_p2_a", {16'd0, port2_a}, 32'd0);
    check_val("mrst_ds", {28'd0, port1_ds, port2_ds}, 32'd0);
    check_val("mrst_d", {port1_d, port2_d}, 32'd0);
    check_val("mrst_we", {30'd0, port1_we, port2_we}, 32'd0);
    check_val("mrst_busy", {31'd0, busy}, 32'd0);
    check_val("mrst_crst", {31'd0, core_reset}, 32'd1);
    check_val("mrst_loaded", {31'd0, rom_loaded}, 32'd0);
    repeat (2) @(negedge clk_sys);
    check_val("mrst_p1_req", {31'd0, port1_req}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
